serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial WIDTH-bit adder with carry-in, the additive counterpart to the team's ripple subtractor cells. It latches two operands on a start request and adds one bit per clock, LSB first, through a single 1-bit full-adder cell. It then presents the registered sum and carry-out with a one-cycle done pulse. It trades latency for area in datapaths where one full-adder cell must serve any operand width.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range 2 to 32.
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; clears all state.
- start  input  1  request to begin an addition; sampled only while busy=0.
- x  input  WIDTH  first operand, captured on the accepting edge.
- y  input  WIDTH  second operand, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: sum and cout have just been updated.
- sum  output  WIDTH  result register (x + y + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.

## Operation
- States: IDLE and RUN.
- Reset (rst_n=0, asynchronous) forces:
  - busy=0, done=0, sum=0, cout=0, state IDLE.
  - Internal shift registers, carry register and bit counter to 0.
- IDLE with start=1 at an edge:
  - Load x and y into their shift registers and cin into the carry register.
  - Clear the bit counter; go to RUN; busy=1.
- RUN, at each edge:
  - The full-adder cell takes the shift-register LSBs and the carry register.
  - Its sum bit shifts into the MSB of the working accumulator.
  - The carry register takes its carry output; both operand registers shift right; the counter increments.
- RUN, at the edge processing bit WIDTH-1:
  - Copy the completed accumulator to sum and the final carry to cout.
  - Assert done for the following cycle; return to IDLE; busy=0.
- start while busy=1 is ignored. It is not queued and has no effect on the operation in progress.
- sum and cout hold their values until the next completion. They do not change during a following run.
- Arithmetic is unsigned modulo 2^WIDTH; cout is bit WIDTH of x + y + cin.
- Counter width is $clog2(WIDTH); it wraps to 0 only through a new start.

## Timing
- Let edge 0 be the edge that accepts start. Bits 0 to WIDTH-1 are processed at edges 1 to WIDTH.
- busy is high in the cycles after edges 0 to WIDTH-1, i.e. exactly WIDTH cycles.
- After edge WIDTH: done=1 for one cycle, busy=0, sum and cout valid.
- Latency from start to done is WIDTH+1 edges. Throughput is one addition per WIDTH+1 cycles.
- start=1 during the done cycle is accepted at the next edge, so back-to-back operation needs no idle gap.
- Reset mid-run: the operation is abandoned, no done pulse is produced, and sum and cout read 0.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package serial_arith_pkg holds:
  - the state enum {IDLE, RUN};
  - the WIDTH range limits, for a future serial_subtractor to reuse.
- One sub-module, fa_bit_cell: a purely combinational 1-bit full adder.
  - Inputs a, b, ci; outputs s = a^b^ci and co = ab | ci(a^b).
  - Instantiated once.
- The top level holds the FSM, shift registers, carry flop, counter and result registers.

## Test plan
- WIDTH=8, x=8'h35, y=8'h4A, cin=0, start pulse -> busy high for 8 cycles, then done for 1 cycle with sum=8'h7F, cout=0.
- x=8'hFF, y=8'h01, cin=0 -> sum=8'h00, cout=1. x=8'hFF, y=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start 8'h10+8'h20; pulse start with x=8'hAA at cycle 3 of the run -> result sum=8'h30 only, a single done pulse, second request dropped.
- rst_n low at cycle 4 of a run of 8'h7F+8'h01 -> busy=0, sum=0, cout=0 at once, no done pulse; a fresh start afterwards completes normally.
- Hold start high through the done cycle with new operands 8'h01+8'h02 -> second run begins at the next edge and gives sum=8'h03. The first sum stays stable until the second done pulse.
- Random sweep at WIDTH=2, 8 and 32 against the x+y+cin reference model. Check done spacing is exactly WIDTH+1 cycles under continuous start.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks (adder, and a future subtractor).
package serial_arith_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/fa_bit_cell.sv
// Single-bit full adder shared across every bit position of a serial operation.
module fa_bit_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder with carry-in: one full-adder cell, LSB first,
// registered sum/cout and a one-cycle done pulse after WIDTH+1 edges.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_adder: WIDTH out of supported range");
    end

    state_e           state;
    state_e           state_nxt;
    logic             load;
    logic             step;
    logic             finish;

    logic [WIDTH-1:0] x_sr;
    logic [WIDTH-1:0] y_sr;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             fa_s;
    logic             fa_co;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;

    fa_bit_cell u_fa (
        .a  (x_sr[0]),
        .b  (y_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Sum bits enter at the MSB so the last bit lands the word in place.
    assign acc_nxt = {fa_s, acc[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST_BIT) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry flop and bit counter; counter parks on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sr  <= '0;
            y_sr  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            x_sr  <= x;
            y_sr  <= y;
            acc   <= '0;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            x_sr  <= x_sr >> 1;
            y_sr  <= y_sr >> 1;
            acc   <= acc_nxt;
            carry <= fa_co;
            if (!finish) begin
                cnt <= CNT_W'(cnt + 1'b1);
            end
        end
    end

    // Result registers only move on completion, so they hold through a following run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == RUN);
            done_q <= finish;
            if (finish) begin
                sum_q  <= acc_nxt;
                cout_q <= fa_co;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH=2, 8 and 32.
module tb_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] xb;
    logic [31:0] yb;
    logic        cin;
    logic        st2, st8, st32;

    logic        busy2, done2, cout2;
    logic [1:0]  sum2;
    logic        busy8, done8, cout8;
    logic [7:0]  sum8;
    logic        busy32, done32, cout32;
    logic [31:0] sum32;

    int errors   = 0;
    int checks   = 0;
    int done_cnt = 0;

    typedef struct {
        int unsigned w;
        logic [31:0] s;
        logic        c;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(st2), .x(xb[1:0]), .y(yb[1:0]), .cin(cin),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    serial_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st8), .x(xb[7:0]), .y(yb[7:0]), .cin(cin),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .start(st32), .x(xb), .y(yb), .cin(cin),
        .busy(busy32), .done(done32), .sum(sum32), .cout(cout32)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int unsigned w, input logic [31:0] a, input logic [31:0] b,
                            input logic ci);
        logic [32:0] mask;
        logic [32:0] full;
        exp_t        e;
        mask  = (33'd1 << w) - 33'd1;
        full  = (33'(a) & mask) + (33'(b) & mask) + 33'(ci);
        e.w   = w;
        e.s   = 32'(full & mask);
        e.c   = full[w];
        sb.push_back(e);
    endtask

    task automatic pop_chk(input int unsigned w, input logic [31:0] s, input logic c);
        exp_t e;
        done_cnt++;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done w%0d: got sum %0h with no pending request", w, s);
        end else begin
            e = sb.pop_front();
            chk($sformatf("w%0d_sum", w), 64'(s), 64'(e.s));
            chk($sformatf("w%0d_cout", w), 64'(c), 64'(e.c));
        end
    endtask

    // Monitor: every done pulse consumes exactly one expected result.
    always @(negedge clk) begin
        if (done2)  pop_chk(2,  32'(sum2),  cout2);
        if (done8)  pop_chk(8,  32'(sum8),  cout8);
        if (done32) pop_chk(32, sum32,      cout32);
    end

    function automatic logic done_of(input int unsigned w);
        case (w)
            2:       return done2;
            8:       return done8;
            default: return done32;
        endcase
    endfunction

    task automatic set_start(input int unsigned w, input logic v);
        case (w)
            2:       st2  = v;
            8:       st8  = v;
            default: st32 = v;
        endcase
    endtask

    // Waits (bounded) for a done pulse at a negedge; returns cycles waited.
    task automatic wait_done(input int unsigned w, output int cyc);
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (done_of(w)) return;
            if (cyc > 200) begin
                chk($sformatf("w%0d_done_timeout", w), 64'(cyc), 64'(0));
                return;
            end
        end
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci);
        int busy_cnt;
        bit got;
        @(posedge clk); #1;
        xb = 32'(a); yb = 32'(b); cin = ci; st8 = 1'b1;
        push_exp(8, 32'(a), 32'(b), ci);
        @(posedge clk); #1;
        st8 = 1'b0;
        busy_cnt = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if (done8) got = 1'b1;
            else if (busy8) busy_cnt++;
        end
        chk("w8_done_seen", 64'(got), 64'(1));
        chk("w8_busy_cycles", 64'(busy_cnt), 64'(8));
        chk("w8_busy_at_done", 64'(busy8), 64'(0));
    endtask

    // Continuous start: new operands are offered in each done cycle.
    task automatic sweep(input int unsigned w, input int n);
        logic [31:0] a, b;
        logic        c;
        int          gap;
        @(posedge clk); #1;
        a = $urandom; b = $urandom; c = 1'($urandom);
        xb = a; yb = b; cin = c;
        set_start(w, 1'b1);
        push_exp(w, a, b, c);
        wait_done(w, gap);
        for (int i = 1; i <= n; i++) begin
            if (i < n) begin
                a = $urandom; b = $urandom; c = 1'($urandom);
                xb = a; yb = b; cin = c;
                push_exp(w, a, b, c);
                wait_done(w, gap);
                chk($sformatf("w%0d_done_spacing", w), 64'(gap), 64'(w + 1));
            end else begin
                set_start(w, 1'b0);
            end
        end
        repeat (w + 4) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc0;
        int gap;
        bit got;

        rst_n = 1'b0;
        xb = '0; yb = '0; cin = 1'b0;
        st2 = 1'b0; st8 = 1'b0; st32 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy8), 64'(0));
        chk("rst_done", 64'(done8), 64'(0));
        chk("rst_sum", 64'(sum8), 64'(0));
        chk("rst_cout", 64'(cout8), 64'(0));
        chk("rst_sum32", 64'(sum32), 64'(0));
        rst_n = 1'b1;

        run8(8'h35, 8'h4A, 1'b0);
        run8(8'hFF, 8'h01, 1'b0);
        run8(8'hFF, 8'hFF, 1'b1);

        // start during a run is dropped
        @(posedge clk); #1;
        xb = 32'h10; yb = 32'h20; cin = 1'b0; st8 = 1'b1;
        push_exp(8, 32'h10, 32'h20, 1'b0);
        @(posedge clk); #1;
        st8 = 1'b0;
        dc0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        xb = 32'hAA; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (20) @(negedge clk);
        chk("ignore_done_count", 64'(done_cnt - dc0), 64'(1));
        chk("ignore_sb_empty", 64'(sb.size()), 64'(0));

        // reset mid-run abandons the operation
        @(posedge clk); #1;
        xb = 32'h7F; yb = 32'h01; cin = 1'b0; st8 = 1'b1;
        @(posedge clk); #1;
        st8 = 1'b0;
        dc0 = done_cnt;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy8), 64'(0));
        chk("midrst_sum", 64'(sum8), 64'(0));
        chk("midrst_cout", 64'(cout8), 64'(0));
        chk("midrst_done", 64'(done8), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        chk("midrst_no_done", 64'(done_cnt - dc0), 64'(0));
        run8(8'h7F, 8'h01, 1'b0);

        // back-to-back with start held through the done cycle
        @(posedge clk); #1;
        xb = 32'h11; yb = 32'h22; cin = 1'b0; st8 = 1'b1;
        push_exp(8, 32'h11, 32'h22, 1'b0);
        @(posedge clk); #1;
        xb = 32'h01; yb = 32'h02;
        push_exp(8, 32'h01, 32'h02, 1'b0);
        wait_done(8, gap);
        @(posedge clk); #1;
        st8 = 1'b0;
        chk("b2b_busy_restart", 64'(busy8), 64'(1));
        gap = 0;
        got = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            gap++;
            if (done8) got = 1'b1;
            else chk("b2b_sum_hold", 64'(sum8), 64'(8'h33));
        end
        chk("b2b_spacing", 64'(gap), 64'(9));

        sweep(2, 12);
        sweep(8, 12);
        sweep(32, 12);

        chk("final_sb_empty", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
